instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Fetch stage directly upstream of the control unit. Walks the PC and issues single-outstanding reads to
//  instruction memory. Buffers returned words with their PC in a small FIFO. Presents the head instruction
//  and its 7-bit opcode to decode/control with a valid/ready handshake, and flushes on branch redirect.
// PARAMETERS
//  INSTR_W   16  instruction word width; opcode = instr[INSTR_W-1 -: OPCODE_W]
//  ADDR_W    16  PC / imem word-address width
//  DEPTH     4   FIFO entries; power of two, >= 2
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-low reset
//  imem_req     out  1         one-cycle read request pulse
//  imem_addr    out  ADDR_W    read address; valid while imem_req=1
//  imem_rvalid  in   1         read data valid; any latency >= 1 cycle after imem_req
//  imem_rdata   in   INSTR_W   read data
//  redirect_en  in   1         flush queue and restart fetch at redirect_pc
//  redirect_pc  in   ADDR_W    new fetch address
//  dec_ready    in   1         decode/control accepts head entry this cycle
//  instr_valid  out  1         head entry valid (= FIFO not empty)
//  instr_out    out  INSTR_W   head instruction
//  instr_pc     out  ADDR_W    PC of head instruction
//  opcode       out  7         instr_out[INSTR_W-1 -: 7], to control unit opcode input
//  fifo_count   out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (reset=0 at clk edge): pc<=RESET_PC, state<=FETCH, FIFO empty. imem_req=0, imem_addr=RESET_PC.
//    instr_valid=0, fifo_count=0. Any in-flight read response is NOT tracked across reset.
//  - FSM states: FETCH, WAIT, DRAIN.
//    FETCH: if fifo_count<DEPTH and !redirect_en: imem_req=1, imem_addr=pc, req_pc<=pc, pc<=pc+1 (wraps mod 2^ADDR_W), ->WAIT.
//           Otherwise imem_req=0 and stay.
//    WAIT: on imem_rvalid, push {req_pc, imem_rdata} and ->FETCH. A new request issues no earlier than the next cycle.
//    DRAIN: on imem_rvalid, discard the data and ->FETCH.
//  - One outstanding read max. Issue is gated on fifo_count<DEPTH at issue time, so a push never overflows.
//  - Pop when instr_valid & dec_ready. Outputs update the cycle after the pop. Push and pop in the same cycle
//    leave the count unchanged.
//  - Push into an empty FIFO: instr_valid=1 the cycle after imem_rvalid. Fetch-to-decode latency = imem latency + 1.
//  - redirect_en (highest priority, overrides push/pop/issue that cycle): FIFO cleared, pc<=redirect_pc.
//    No request is issued that cycle.
//      FETCH -> FETCH
//      WAIT with no imem_rvalid -> DRAIN
//      WAIT with imem_rvalid -> FETCH, data dropped
//      DRAIN -> DRAIN (pending response still discarded)
//    The first request at redirect_pc issues the cycle after leaving the flush/drain.
//  - instr_out, instr_pc and opcode are driven from FIFO storage. Their value is don't-care when instr_valid=0.
//    Outputs hold stable while instr_valid=1 and dec_ready=0.
//  - imem_rvalid in FETCH is a protocol error: ignored, no push.
// STRUCTURE
//  - Shared package: OPCODE_W=7, fetch FSM state typedef {FETCH, WAIT, DRAIN}, INSTR_W/ADDR_W defaults.
//  - Sub-module: sync_fifo (DEPTH x (ADDR_W+INSTR_W), push/pop/clear, count/empty/full).
//  - Top level: PC register, FSM, opcode slice.
// TESTING
//  1. Reset, 1-cycle imem, dec_ready=1 -> imem_addr 0,1,2... Each instruction valid 2 cycles after its request.
//     opcode matches bits[15:9] (e.g. 0x2200 -> 7'b0010001).
//  2. dec_ready=0, 1-cycle imem -> exactly 4 requests (addr 0..3), fifo_count=4, imem_req stays 0.
//     Raise dec_ready -> PCs 0,1,2,3 pop in order and fetch resumes at addr 4.
//  3. 3-cycle imem latency, redirect_en (pc=0x40) one cycle after the req for addr 5 -> FIFO empties
//     and the late response is dropped. Next imem_addr=0x40. No PC-5 entry ever appears at instr_pc.
//  4. redirect_en in the same cycle as imem_rvalid in WAIT -> data dropped, state FETCH.
//     Request to redirect_pc the next cycle.
//  5. pc=0xFFFF with ADDR_W=16 -> the following request addr is 0x0000.
//  6. reset=0 asserted with FIFO holding 3 entries and a request in flight -> next cycle instr_valid=0,
//     fifo_count=0, imem_req=0. After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: opcode width,
// default bus widths and the fetch FSM state encoding.
package instr_prefetch_queue_pkg;

    localparam int OPCODE_W    = 7;
    localparam int INSTR_W_DEF = 16;
    localparam int ADDR_W_DEF  = 16;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Small synchronous FIFO with clear, occupancy count and a combinational head
// read so the head entry is visible the cycle after it is written.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && reset && !clear) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: walks the PC, keeps one read outstanding to instruction memory,
// queues returned words with their PC and hands them to decode.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_rvalid,
    input  logic [INSTR_W-1:0]       imem_rdata,
    input  logic                     redirect_en,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     dec_ready,
    output logic                     instr_valid,
    output logic [INSTR_W-1:0]       instr_out,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [OPCODE_W-1:0]      opcode,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int ENTRY_W = ADDR_W + INSTR_W;

    fetch_state_t        state_reg;
    fetch_state_t        state_next;
    logic [ADDR_W-1:0]   pc_reg;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   req_pc_reg;
    logic                issue;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [ENTRY_W-1:0]  head_entry;

    // A request made while reset is held would be lost at the reset edge, so none is issued.
    assign issue = reset && (state_reg == ST_FETCH) && !fifo_full && !redirect_en;
    assign push  = (state_reg == ST_WAIT) && imem_rvalid && !redirect_en;
    assign pop   = !fifo_empty && dec_ready && !redirect_en;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_en) begin
            pc_next = redirect_pc;
            unique case (state_reg)
                ST_WAIT:  state_next = imem_rvalid ? ST_FETCH : ST_DRAIN;
                ST_DRAIN: state_next = ST_DRAIN;
                default:  state_next = ST_FETCH;
            endcase
        end else begin
            unique case (state_reg)
                ST_FETCH: begin
                    if (issue) begin
                        state_next = ST_WAIT;
                        pc_next    = pc_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_next = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_next = ST_FETCH;
                    end
                end
                default: state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= RESET_PC;
            req_pc_reg <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (issue) begin
                req_pc_reg <= pc_reg;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect_en),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc_reg, imem_rdata}),
        .rdata (head_entry),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc_reg;
    assign instr_valid = !fifo_empty;
    assign instr_pc    = head_entry[ENTRY_W-1:INSTR_W];
    assign instr_out   = head_entry[INSTR_W-1:0];
    assign opcode      = instr_out[INSTR_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for the prefetch queue: a cycle table for steady fetch and
// backpressure, then hand sequences for redirect, PC wrap and reset mid-flight.
module tb_instr_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        dec_ready;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    int          mem_lat = 1;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = '0;
    bit          watch_pc5 = 0;
    bit          saw_pc5 = 0;

    instr_prefetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .fifo_count  (fifo_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Memory image: word at address a has opcode a[6:0]+0x11, low bits a[8:0].
    function automatic logic [15:0] mem_data(input logic [15:0] a);
        logic [6:0] op;
        op = a[6:0] + 7'h11;
        return {op, a[8:0]};
    endfunction

    function automatic logic [6:0] mem_op(input logic [15:0] a);
        return a[6:0] + 7'h11;
    endfunction

    // Instruction memory with programmable latency, evaluated mid-cycle.
    initial begin
        imem_rvalid = 0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 0;
            if (pend) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1;
                    imem_rdata  = mem_data(pend_addr);
                    pend        = 0;
                end
            end
            if (imem_req) begin
                pend      = 1;
                pend_addr = imem_addr;
                pend_cnt  = mem_lat;
            end
            if (watch_pc5 && instr_valid && instr_pc == 16'd5) saw_pc5 = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns in the settled part of the first cycle showing imem_req=1.
    task automatic wait_req(input int max, output int n, output bit ok);
        ok = 0;
        n  = 0;
        for (int i = 0; i <= max; i++) begin
            #1;
            if (imem_req) begin
                ok = 1;
                n  = i;
                break;
            end
            cyc();
        end
    endtask

    task automatic do_reset();
        reset       = 0;
        redirect_en = 0;
        repeat (5) cyc();
        reset = 1;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic rdy, input logic req,
                               input logic [15:0] addr, input logic vld,
                               input logic [15:0] pc, input logic [2:0] cnt);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.req = req; r.addr = addr;
        r.vld = vld; r.pc = pc; r.cnt = cnt;
        return r;
    endfunction

    int n;
    bit ok;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, rdy, req, addr, vld, pc, cnt
        vecs.push_back(v(0, 1, 0, 16'd0, 0, 16'd0, 3'd0));  // reset state
        vecs.push_back(v(1, 1, 1, 16'd0, 0, 16'd0, 3'd0));  // steady fetch, 1-cycle memory
        vecs.push_back(v(1, 1, 0, 16'd0, 0, 16'd0, 3'd0));
        vecs.push_back(v(1, 1, 1, 16'd1, 1, 16'd0, 3'd1));
        vecs.push_back(v(1, 1, 0, 16'd0, 0, 16'd0, 3'd0));
        vecs.push_back(v(1, 1, 1, 16'd2, 1, 16'd1, 3'd1));
        vecs.push_back(v(1, 1, 0, 16'd0, 0, 16'd0, 3'd0));
        vecs.push_back(v(1, 1, 1, 16'd3, 1, 16'd2, 3'd1));
        vecs.push_back(v(0, 1, 0, 16'd0, 0, 16'd0, 3'd0));  // reset with addr 3 in flight
        vecs.push_back(v(0, 0, 0, 16'd0, 0, 16'd0, 3'd0));
        vecs.push_back(v(1, 0, 1, 16'd0, 0, 16'd0, 3'd0));  // decode stalled, fill to 4
        vecs.push_back(v(1, 0, 0, 16'd0, 0, 16'd0, 3'd0));
        vecs.push_back(v(1, 0, 1, 16'd1, 1, 16'd0, 3'd1));
        vecs.push_back(v(1, 0, 0, 16'd0, 1, 16'd0, 3'd1));
        vecs.push_back(v(1, 0, 1, 16'd2, 1, 16'd0, 3'd2));
        vecs.push_back(v(1, 0, 0, 16'd0, 1, 16'd0, 3'd2));
        vecs.push_back(v(1, 0, 1, 16'd3, 1, 16'd0, 3'd3));
        vecs.push_back(v(1, 0, 0, 16'd0, 1, 16'd0, 3'd3));
        vecs.push_back(v(1, 0, 0, 16'd0, 1, 16'd0, 3'd4));
        vecs.push_back(v(1, 0, 0, 16'd0, 1, 16'd0, 3'd4));
        vecs.push_back(v(1, 1, 0, 16'd0, 1, 16'd0, 3'd4));  // decode resumes
        vecs.push_back(v(1, 1, 1, 16'd4, 1, 16'd1, 3'd3));
        vecs.push_back(v(1, 1, 0, 16'd0, 1, 16'd2, 3'd2));
        vecs.push_back(v(1, 1, 1, 16'd5, 1, 16'd3, 3'd2));
        vecs.push_back(v(1, 1, 0, 16'd0, 1, 16'd4, 3'd1));
        vecs.push_back(v(1, 1, 1, 16'd6, 1, 16'd5, 3'd1));
        vecs.push_back(v(1, 0, 0, 16'd0, 0, 16'd0, 3'd0));
        vecs.push_back(v(1, 0, 1, 16'd7, 1, 16'd6, 3'd1));

        reset       = 0;
        dec_ready   = 1;
        redirect_en = 0;
        redirect_pc = '0;
        mem_lat     = 1;
        repeat (4) cyc();

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            dec_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(vecs[i].pc));
                chk($sformatf("vec%0d_instr", i), 32'(instr_out), 32'(mem_data(vecs[i].pc)));
                chk($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(mem_op(vecs[i].pc)));
            end
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
            $display("vec %0d: req=%b addr=%h valid=%b pc=%h op=%b count=%0d",
                     i, imem_req, imem_addr, instr_valid, instr_pc, opcode, fifo_count);
            cyc();
        end

        // Opcode of the word at address 0 (0x2200).
        chk("opcode_const", 32'(mem_op(16'd0)), 32'(7'b0010001));

        // Redirect while a 3-cycle read for addr 5 is outstanding.
        mem_lat   = 3;
        dec_ready = 1;
        do_reset();
        watch_pc5 = 1;
        saw_pc5   = 0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (imem_req && imem_addr == 16'd5) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk("t3_req5_seen", 32'(ok), 32'd1);
        cyc();
        redirect_en = 1;
        redirect_pc = 16'h0040;
        #1;
        chk("t3_no_req_on_redirect", 32'(imem_req), 32'd0);
        cyc();
        redirect_en = 0;
        #1;
        chk("t3_flush_count", 32'(fifo_count), 32'd0);
        chk("t3_flush_valid", 32'(instr_valid), 32'd0);
        cyc();
        wait_req(10, n, ok);
        chk("t3_req_after_drain", 32'(ok), 32'd1);
        chk("t3_drain_cycles", 32'(n), 32'd1);
        chk("t3_redirect_addr", 32'(imem_addr), 32'h0040);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            if (instr_valid) begin
                ok = 1;
                break;
            end
        end
        chk("t3_valid_after_redirect", 32'(ok), 32'd1);
        chk("t3_head_pc", 32'(instr_pc), 32'h0040);
        chk("t3_head_instr", 32'(instr_out), 32'(mem_data(16'h0040)));
        watch_pc5 = 0;
        chk("t3_no_pc5_entry", 32'(saw_pc5), 32'd0);
        $display("t3: redirect during outstanding read done");

        // Redirect coinciding with the read response.
        mem_lat   = 2;
        dec_ready = 1;
        do_reset();
        wait_req(10, n, ok);
        chk("t4_first_req", 32'(ok), 32'd1);
        cyc();
        cyc();
        redirect_en = 1;
        redirect_pc = 16'h0080;
        #1;
        chk("t4_no_req_on_redirect", 32'(imem_req), 32'd0);
        cyc();
        redirect_en = 0;
        #1;
        chk("t4_req_next", 32'(imem_req), 32'd1);
        chk("t4_req_addr", 32'(imem_addr), 32'h0080);
        chk("t4_data_dropped", 32'(instr_valid), 32'd0);
        chk("t4_count", 32'(fifo_count), 32'd0);
        $display("t4: redirect with simultaneous response done");

        // PC wrap from 0xFFFF to 0x0000.
        mem_lat   = 1;
        dec_ready = 1;
        do_reset();
        redirect_en = 1;
        redirect_pc = 16'hFFFF;
        cyc();
        redirect_en = 0;
        wait_req(10, n, ok);
        chk("t5_req_ffff_seen", 32'(ok), 32'd1);
        chk("t5_req_ffff_delay", 32'(n), 32'd0);
        chk("t5_addr_ffff", 32'(imem_addr), 32'hFFFF);
        cyc();
        cyc();
        #1;
        chk("t5_valid", 32'(instr_valid), 32'd1);
        chk("t5_head_pc", 32'(instr_pc), 32'hFFFF);
        chk("t5_wrap_req", 32'(imem_req), 32'd1);
        chk("t5_wrap_addr", 32'(imem_addr), 32'h0000);
        $display("t5: pc wrap done");

        // Reset with three entries queued and a read in flight.
        mem_lat   = 2;
        dec_ready = 0;
        do_reset();
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (imem_req && fifo_count == 3'd3) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk("t6_fill3", 32'(ok), 32'd1);
        cyc();
        reset = 0;
        #1;
        chk("t6_pre_count", 32'(fifo_count), 32'd3);
        chk("t6_pre_valid", 32'(instr_valid), 32'd1);
        cyc();
        #1;
        chk("t6_rst_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_count", 32'(fifo_count), 32'd0);
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        cyc();
        reset = 1;
        #1;
        chk("t6_first_req", 32'(imem_req), 32'd1);
        chk("t6_first_addr", 32'(imem_addr), 32'h0000);
        cyc();
        #1;
        chk("t6_no_stray_push", 32'(fifo_count), 32'd0);
        $display("t6: reset with read in flight done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
